// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  localparam int BUNDLE_ALIGN_BITS = 4;

  // Fetch restarts on bundle boundaries, so the low bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:BUNDLE_ALIGN_BITS], {BUNDLE_ALIGN_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/branch_prio_sel.sv
// Lowest-index (oldest slot) winner select: one-hot grant plus the granted target.
module branch_prio_sel #(
  parameter int NUM_BR = 2
) (
  input  logic [NUM_BR-1:0]    req,
  input  logic [NUM_BR*32-1:0] target,
  output logic [NUM_BR-1:0]    grant,
  output logic [31:0]          sel_target
);

  logic found;

  always_comb begin
    grant      = '0;
    sel_target = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (req[i] && !found) begin
        grant[i]   = 1'b1;
        sel_target = target[32*i +: 32];
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Arbitrates resolved taken branches into a single fetch redirect followed by a squash window.
// Optional statistics counters are enabled with macro BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int NUM_BR       = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BR-1:0]    br_valid,
  input  logic [NUM_BR-1:0]    br_taken,
  input  logic [NUM_BR*32-1:0] br_target,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  input  logic                 redirect_ready,
  output logic                 flush,
  output logic                 busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]          taken_cnt,
  output logic [31:0]          redirect_cnt
`endif
);

  localparam logic [3:0] CNT_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  br_state_e         state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       pc_nxt;
  logic [NUM_BR-1:0] grant;
  logic [31:0]       sel_target;
  logic              winner;
  logic              capture;
  logic              handshake;

  branch_prio_sel #(.NUM_BR(NUM_BR)) u_prio_sel (
    .req        (br_valid & br_taken),
    .target     (br_target),
    .grant      (grant),
    .sel_target (sel_target)
  );

  assign winner = |grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      redirect_pc <= pc_nxt;
    end
  end

  // Branch inputs are only looked at in IDLE; anything arriving later is wrong-path.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = redirect_pc;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (winner) begin
          capture   = 1'b1;
          pc_nxt    = align_pc(sel_target);
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          handshake = 1'b1;
          if (FLUSH_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode the registered state only.
  assign redirect_valid = (state == REDIRECT);
  assign busy           = (state != IDLE);
  assign flush          = busy;

`ifdef BRANCH_REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (capture && (taken_cnt != 32'hFFFF_FFFF))      taken_cnt    <= taken_cnt + 32'd1;
      if (handshake && (redirect_cnt != 32'hFFFF_FFFF)) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = capture ^ handshake;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter NUM_BR, default 2: number of branch-execute slots arbitrated, legal range 1..4.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: squash cycles after the redirect handshake, legal range 0..15.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port br_valid  input  NUM_BR  per-slot resolved-branch strobe; bit 0 is the oldest slot.
REQ-007 SHALL have port br_taken  input  NUM_BR  per-slot branch_taken.
REQ-008 SHALL have port br_target  input  NUM_BR*32  per-slot new_pc; slot i occupies bits [32*i+31:32*i].
REQ-009 SHALL have port redirect_valid  output  1  fetch redirect request.
REQ-010 SHALL have port redirect_pc  output  32  fetch redirect target.
REQ-011 SHALL have port redirect_ready  input  1  fetch accepts the redirect.
REQ-012 SHALL have port flush  output  1  squash of younger bundles in the pipeline.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, REDIRECT and FLUSH.
REQ-015 In IDLE, a winner SHALL exist when any slot has br_valid&br_taken; the winner SHALL be the lowest index.
REQ-016 In IDLE with a winner, SHALL latch the winner target with bits [3:0] forced to 0 (bundle alignment) and go to REDIRECT on the next edge.
REQ-017 Valid branches that are not taken SHALL cause no state change and no redirect.
REQ-018 Taken branches in higher slots than the winner, in the same cycle, SHALL be discarded.
REQ-019 br_* inputs SHALL be ignored in REDIRECT and FLUSH, because they are wrong-path.
REQ-020 redirect_valid SHALL be 1 exactly while in REDIRECT; redirect_pc SHALL stay stable until the handshake.
REQ-021 The handshake SHALL be redirect_valid&redirect_ready sampled on an edge; redirect_ready asserted outside REDIRECT SHALL be ignored.
REQ-022 On handshake, SHALL go to FLUSH with the counter loaded to FLUSH_CYCLES-1, or go straight to IDLE when FLUSH_CYCLES==0.
REQ-023 In FLUSH, SHALL decrement the counter each cycle and go to IDLE on the edge where the counter is 0.
REQ-024 flush SHALL equal busy: state not IDLE, registered, with no combinational path from inputs.
REQ-025 Latency SHALL be 1 cycle from the winner-present edge to redirect_valid=1.
REQ-026 Minimum gap from the winner to the next accepted winner SHALL be 2+FLUSH_CYCLES cycles when ready is held high.
REQ-027 redirect_pc SHALL hold its last value when not in REDIRECT.

Reset
REQ-028 While rst_n=0 on an edge, SHALL force state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, busy=0, counter=0 and all stats counters to 0.
REQ-029 Reset SHALL take priority over everything, including mid-handshake or mid-FLUSH; the pending redirect SHALL be dropped.

Configuration
REQ-030 With macro BRANCH_REDIRECT_STATS_EN defined, SHALL add outputs taken_cnt (32) and redirect_cnt (32).
REQ-031 taken_cnt SHALL increment once per winner capture; redirect_cnt SHALL increment once per handshake; both SHALL saturate at 32'hFFFFFFFF.
REQ-032 Without BRANCH_REDIRECT_STATS_EN, the stats ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The FSM state enum (IDLE/REDIRECT/FLUSH) and the constant BUNDLE_ALIGN_BITS=4 SHALL live in shared package branch_pkg.
REQ-034 Winner selection SHALL be a sub-module branch_prio_sel: combinational lowest-index select returning a one-hot grant and the selected target.

Verification
REQ-035 SHALL verify: slot1 taken, target 32'h0000_1238, ready=1 -> redirect_valid the next cycle with redirect_pc 32'h0000_1230; flush high for 1+2 cycles.
REQ-036 SHALL verify: slot0 and slot1 both taken, targets 32'h100 / 32'h200 -> redirect_pc 32'h100 only; one handshake.
REQ-037 SHALL verify: ready held low for 5 cycles -> redirect_valid and redirect_pc stable for 5 cycles; new taken branches ignored.
REQ-038 SHALL verify: valid=1, taken=0 on all slots for 10 cycles -> busy stays 0, no redirect.
REQ-039 SHALL verify: rst_n low for 1 cycle during FLUSH -> state IDLE next cycle, flush=0, busy=0, counters 0.
REQ-040 SHALL verify: FLUSH_CYCLES=0 with BRANCH_REDIRECT_STATS_EN defined, three back-to-back taken branches -> IDLE reached immediately after each handshake; taken_cnt=3 and redirect_cnt=3.
